// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the instruction-memory, redirect and decode handshake signals of the
// fetch controller.
//   imem_addr      fetch -> memory   byte address (equals pc)
//   imem_data      memory -> fetch   instruction word for imem_addr
//   redirect_valid core -> fetch     load redirect_pc and flush
//   redirect_pc    core -> fetch     redirect target
//   ins_valid      fetch -> decode   head entry valid
//   ins_ready      decode -> fetch   head accepted this cycle
//   ins_word       fetch -> decode   instruction at head
//   ins_pc         fetch -> decode   pc of instruction at head
// Modport master is the fetch controller's view; slave is the memory/decode/core side.
interface fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_word;
    logic [31:0] ins_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output ins_valid,
        input  ins_ready,
        output ins_word,
        output ins_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  ins_valid,
        output ins_ready,
        input  ins_word,
        input  ins_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller. Owns the PC, addresses instruction memory
// combinationally and buffers {pc, word} pairs in a DEPTH-entry FIFO for decode.
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   run    fetch enable; when low the FIFO still drains
//   bus    fetch_ctrl_if.master: imem address/data, redirect, decode valid/ready/word/pc
//   fault  sticky misaligned-redirect flag, cleared by rst or an aligned redirect
//   oob    high while the pc is past the end of instruction memory
//   count  FIFO occupancy
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int unsigned IMEM_BYTES = 80,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    fetch_ctrl_if.master             bus,
    output logic                     fault,
    output logic                     oob,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StFetch, StOob, StFault} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       word_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];

    logic [32:0]       pc_end;
    logic              in_range;
    logic              pop;
    logic              push;

    // 33-bit compare so a pc near 2^32 is never mistaken for in range.
    assign pc_end   = {1'b0, pc_q} + 33'd4;
    assign in_range = (pc_end <= 33'(IMEM_BYTES));

    assign pop  = (cnt_q != '0) && bus.ins_ready;
    assign push = (state_q == StFetch) && run && !bus.redirect_valid && in_range &&
                  ((cnt_q < CntW'(DEPTH)) || pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        if (bus.redirect_valid) begin
            // Flush wins over any pop in the same cycle; that head is simply dropped.
            cnt_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            pc_d    = bus.redirect_pc;
            state_d = (bus.redirect_pc[1:0] != 2'b00) ? StFault : StFetch;
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
                pc_d   = pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            cnt_d = cnt_q + CntW'(push) - CntW'(pop);
            case (state_q)
                StFetch: if (!in_range) state_d = StOob;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset: the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            word_mem[tail_q] <= bus.imem_data;
            pc_mem[tail_q]   <= pc_q;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.ins_valid = (cnt_q != '0);
    assign bus.ins_word  = (cnt_q != '0) ? word_mem[head_q] : 32'h0;
    assign bus.ins_pc    = (cnt_q != '0) ? pc_mem[head_q] : 32'h0;
    assign fault         = (state_q == StFault);
    assign oob           = (state_q == StOob);
    assign count         = cnt_q;

endmodule
